// File: rtl/lcd_fifo_rd_sched.sv
// lcd_fifo_rd_sched: read-side scheduler for the LCD pixel FIFO.
// Generates line/frame timing, pops one 32-bit word (two RGB565 pixels) per
// even active position, gates frame start on FIFO fill level and contains
// underruns by painting UNDERRUN_RGB until the end of the frame.
// Optional feature macro: LCD_FIFO_SCHED_UNDERRUN_CNT_EN adds the 16-bit
// saturating underrun_cnt output.
module lcd_fifo_rd_sched #(
  parameter int unsigned H_ACTIVE     = 480,
  parameter int unsigned H_FP         = 8,
  parameter int unsigned H_SYNC       = 4,
  parameter int unsigned H_BP         = 43,
  parameter int unsigned V_ACTIVE     = 272,
  parameter int unsigned V_FP         = 4,
  parameter int unsigned V_SYNC       = 4,
  parameter int unsigned V_BP         = 12,
  parameter logic [15:0] UNDERRUN_RGB = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] fifo_rd_data,
  input  logic        fifo_rd_empty,
  input  logic        fifo_almost_empty,
  output logic        fifo_rd_en,
  output logic        frame_start,
  output logic        resync,
  output logic        underrun,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic [15:0] lcd_rgb
`ifdef LCD_FIFO_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  // Region bounds expressed as inclusive last positions so a zero-width
  // back porch cannot overflow the counter width.
  localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FILL,
    RUN,
    UNDERRUN
  } state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic running;
  logic in_active;
  logic in_hs;
  logic in_vs;
  logic h_even;
  logic h_wrap;
  logic frame_first;
  logic frame_last;
  logic pop_slot;
  logic ur_hit;

  // Stage-1 pixel pipeline flags
  logic s1_de;
  logic s1_hs;
  logic s1_vs;
  logic s1_even;
  logic s1_ur;
  logic s1_pop;

  logic [15:0] pix_hold;

  // Counter decodes, pop strobe and underrun detection in the counter cycle
  always_comb begin
    running     = (state != IDLE);
    in_active   = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
    in_hs       = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
    in_vs       = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
    h_even      = ~h_cnt[0];
    h_wrap      = (h_cnt == H_LAST);
    frame_first = (h_cnt == '0) && (v_cnt == '0);
    frame_last  = h_wrap && (v_cnt == V_LAST);
    pop_slot    = (state == RUN) && in_active && h_even;
    ur_hit      = pop_slot && fifo_rd_empty;
    fifo_rd_en  = pop_slot && !fifo_rd_empty;
  end

  // Scheduler FSM, timing counters, event pulses and stage-1 pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      resync      <= 1'b0;
      underrun    <= 1'b0;
      s1_de       <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_even     <= 1'b0;
      s1_ur       <= 1'b0;
      s1_pop      <= 1'b0;
    end else if (!en) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      resync      <= 1'b0;
      underrun    <= 1'b0;
      s1_de       <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_even     <= 1'b0;
      s1_ur       <= 1'b0;
      s1_pop      <= 1'b0;
    end else begin
      frame_start <= running && frame_first;
      resync      <= ur_hit;
      if (ur_hit) begin
        underrun <= 1'b1;
      end

      s1_de   <= running && in_active;
      s1_hs   <= !(running && in_hs);
      s1_vs   <= !(running && in_vs);
      s1_even <= h_even;
      s1_ur   <= ur_hit || (state == UNDERRUN);
      s1_pop  <= fifo_rd_en;

      if (!running) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      case (state)
        IDLE:      state <= WAIT_FILL;
        WAIT_FILL: if (frame_last && !fifo_almost_empty) state <= RUN;
        RUN:       if (ur_hit) state <= UNDERRUN;
        UNDERRUN:  if (frame_last) state <= WAIT_FILL;
        default:   state <= IDLE;
      endcase
    end
  end

  // Stage-2 pin registers; even pixel taken from the popped word, odd from hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_de   <= 1'b0;
      lcd_hs   <= 1'b1;
      lcd_vs   <= 1'b1;
      lcd_rgb  <= '0;
      pix_hold <= '0;
    end else if (!en) begin
      lcd_de   <= 1'b0;
      lcd_hs   <= 1'b1;
      lcd_vs   <= 1'b1;
      lcd_rgb  <= '0;
      pix_hold <= '0;
    end else begin
      lcd_de <= s1_de;
      lcd_hs <= s1_hs;
      lcd_vs <= s1_vs;
      if (!s1_de) begin
        lcd_rgb <= '0;
      end else if (s1_ur) begin
        lcd_rgb <= UNDERRUN_RGB;
      end else if (s1_even) begin
        // No pop (WAIT_FILL) yields black on both pixels of the pair
        lcd_rgb  <= s1_pop ? fifo_rd_data[15:0]  : '0;
        pix_hold <= s1_pop ? fifo_rd_data[31:16] : '0;
      end else begin
        lcd_rgb <= pix_hold;
      end
    end
  end

`ifdef LCD_FIFO_SCHED_UNDERRUN_CNT_EN
  // Saturating count of RUN -> UNDERRUN entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (!en) begin
      underrun_cnt <= '0;
    end else if (ur_hit && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_fifo_rd_sched.sv
// tb_lcd_fifo_rd_sched: scoreboard bench for lcd_fifo_rd_sched using a
// 14 x 7 timing (8 active pixels, 4 active lines, 98-cycle frame).
module tb_lcd_fifo_rd_sched;

  localparam int HT = 14;
  localparam int FT = 98;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_empty;
  logic        fifo_almost_empty;
  logic        fifo_rd_en;
  logic        frame_start;
  logic        resync;
  logic        underrun;
  logic        lcd_de;
  logic        lcd_hs;
  logic        lcd_vs;
  logic [15:0] lcd_rgb;
`ifdef LCD_FIFO_SCHED_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 clk = ~clk;

  lcd_fifo_rd_sched #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .UNDERRUN_RGB(16'hF800)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_rd_en(fifo_rd_en),
    .frame_start(frame_start),
    .resync(resync),
    .underrun(underrun),
    .lcd_de(lcd_de),
    .lcd_hs(lcd_hs),
    .lcd_vs(lcd_vs),
    .lcd_rgb(lcd_rgb)
`ifdef LCD_FIFO_SCHED_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  // FIFO model: word n = 0xAAAA_0000 + n, data valid the cycle after the pop
  logic [31:0] mem [64];
  int unsigned wr_cnt = 0;
  int unsigned rd_ptr = 0;

  always_comb fifo_rd_empty = (rd_ptr >= wr_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Cycle index since enable: 0 is the first cycle after en is sampled high
  int ccnt = 0;
  int cyc;
  always @(posedge clk) begin
    if (!en) ccnt <= 0;
    else     ccnt <= ccnt + 1;
  end
  always_comb cyc = ccnt - 1;

  logic [15:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int run   = 0;
  int done  = 0;
  int tmo   = 0;

  int pops   [10];
  int de_cnt [10];
  int pexp   [9] = '{0, 16, 4, 0, 0, 0, 0, 16, 10};
  int resync_cnt = 0;
  int bad_en     = 0;
  int dis_age    = 0;
  logic p_hs = 1'b1;
  logic p_vs = 1'b1;
  logic p_de = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_const(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(16'(first + i));
      exp_q.push_back(16'hAAAA);
    end
  endtask

  task automatic go_to(input int n);
    int g = 0;
    while (cyc != n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) tmo++;
  endtask

  // Stimulus
  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    fifo_almost_empty = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hAAAA_0000 + 32'(i);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wr_cnt = 20;
    push_const(16'h0000, 32);      // frame 0: WAIT_FILL
    push_words(0, 16);             // frame 1: RUN
    push_words(16, 4);             // frame 2: 4 pops then underrun
    push_const(16'hF800, 24);
    push_const(16'h0000, 4 * 32);  // frames 3..6: WAIT_FILL
    push_words(20, 16);            // frame 7: RUN
    push_words(36, 9);             // frame 8: two lines plus one pair
    run = 1;
    en  = 1'b1;
    go_to(250);
    fifo_almost_empty = 1'b1;
    go_to(598);
    wr_cnt = 52;
    fifo_almost_empty = 1'b0;
    go_to(815);                    // h_cnt=3, v_cnt=2
    en = 1'b0;
    repeat (5) @(negedge clk);
    run = 2;
    push_const(16'h0000, 8);
    en = 1'b1;
    go_to(12);                     // pins in hsync
    #2 rst_n = 1'b0;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    done = 1;
  end

  // Monitor / scoreboard
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      chk("rst_fifo_rd_en", int'(fifo_rd_en), 0);
      chk("rst_frame_start", int'(frame_start), 0);
      chk("rst_resync", int'(resync), 0);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_lcd_de", int'(lcd_de), 0);
      chk("rst_lcd_hs", int'(lcd_hs), 1);
      chk("rst_lcd_vs", int'(lcd_vs), 1);
      chk("rst_lcd_rgb", int'(lcd_rgb), 0);
      p_hs = 1'b1;
      p_vs = 1'b1;
      p_de = 1'b0;
    end else begin
      if (lcd_de) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pixel_extra: got 0x%0h, want no pixel (t=%0t)", lcd_rgb, $time);
        end else begin
          chk("pixel", int'(lcd_rgb), int'(exp_q.pop_front()));
        end
      end
      if (fifo_rd_en) begin
        if (fifo_rd_empty) bad_en++;
        if (cyc < 0 || (cyc % HT) >= 8 || (cyc % 2) != 0 || ((cyc % FT) / HT) >= 4) bad_en++;
        else if (run == 1 && cyc / FT < 10) pops[cyc / FT]++;
      end
      if (run == 1 && lcd_de && cyc >= 2 && (cyc - 2) / FT < 8) de_cnt[(cyc - 2) / FT]++;
      if (run == 1 && resync) begin
        resync_cnt++;
        chk("resync_cyc", cyc, 211);
      end
      if (en && cyc >= 0) begin
        if (!lcd_hs && p_hs) chk("hs_fall", cyc % HT, 12);
        if (lcd_hs && !p_hs) chk("hs_rise", cyc % HT, 0);
        if (!lcd_vs && p_vs) chk("vs_fall", cyc % FT, 72);
        if (lcd_vs && !p_vs) chk("vs_rise", cyc % FT, 86);
        if (lcd_de && !p_de) chk("de_rise", cyc % HT, 2);
        if (!lcd_de && p_de) chk("de_fall", cyc % HT, 10);
        if (frame_start) chk("frame_start", cyc % FT, 1);
      end
      if (run == 1 && en) begin
        if (cyc == 195) chk("underrun_pre", int'(underrun), 0);
        if (cyc == 211) chk("underrun_set", int'(underrun), 1);
        if (cyc == 815) chk("underrun_sticky", int'(underrun), 1);
`ifdef LCD_FIFO_SCHED_UNDERRUN_CNT_EN
        if (cyc == 300) chk("underrun_cnt", int'(underrun_cnt), 1);
`endif
      end
      if (en) dis_age = 0;
      else if (dis_age < 100) dis_age++;
      if (run == 1 && dis_age == 2) begin
        chk("dis_fifo_rd_en", int'(fifo_rd_en), 0);
        chk("dis_lcd_de", int'(lcd_de), 0);
        chk("dis_lcd_hs", int'(lcd_hs), 1);
        chk("dis_lcd_vs", int'(lcd_vs), 1);
        chk("dis_lcd_rgb", int'(lcd_rgb), 0);
        chk("dis_underrun", int'(underrun), 0);
`ifdef LCD_FIFO_SCHED_UNDERRUN_CNT_EN
        chk("dis_underrun_cnt", int'(underrun_cnt), 0);
`endif
      end
      p_hs = lcd_hs;
      p_vs = lcd_vs;
      p_de = lcd_de;
    end
    if (done != 0) begin
      for (int f = 0; f < 9; f++) chk($sformatf("pops_frame%0d", f), pops[f], pexp[f]);
      for (int f = 0; f < 8; f++) chk($sformatf("de_frame%0d", f), de_cnt[f], 32);
      chk("resync_count", resync_cnt, 1);
      chk("bad_pop", bad_en, 0);
      chk("pixels_left", exp_q.size(), 0);
      chk("timeout", tmo, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
